fpu_pcpi_sequencer: RTL and testbench

- PCPI co-processor controller between the picorv32 PCPI port and one shared single-precision FPU core.
- Decodes OP-FP instructions (fadd.s/fsub.s/fmul.s), latches operands, issues one start pulse to the FPU, waits for done, then returns the result through the PCPI ready/wr/rd handshake.
- Sequences exactly one FPU operation at a time. Handles an aborted PCPI request and, optionally, a hung FPU.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_insn_decode.sv | 40 ++++
 rtl/fpu_pcpi_sequencer.sv | 134 +++++++++++++
 tb/tb_fpu_pcpi_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants for the FPU PCPI blocks: opcode/funct7 encodings, FPU op codes,
// the canonical NaN and the sequencer state encoding.
package fpu_pkg;

    localparam logic [6:0]  OPCODE_OP_FP   = 7'h53;
    localparam logic [6:0]  FUNCT7_FADD    = 7'h00;
    localparam logic [6:0]  FUNCT7_FSUB    = 7'h04;
    localparam logic [6:0]  FUNCT7_FMUL    = 7'h08;

    localparam logic [1:0]  FPU_OP_ADD     = 2'd0;
    localparam logic [1:0]  FPU_OP_SUB     = 2'd1;
    localparam logic [1:0]  FPU_OP_MUL     = 2'd2;

    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_ISSUE = 3'd1;
    localparam seq_state_t ST_WAIT  = 3'd2;
    localparam seq_state_t ST_RESP  = 3'd3;
    localparam seq_state_t ST_DRAIN = 3'd4;
    localparam seq_state_t ST_ABORT = 3'd5;

endpackage

// File: rtl/fpu_insn_decode.sv
// Combinational OP-FP decoder: recognises fadd.s/fsub.s/fmul.s and maps them to an
// FPU op code. The rounding-mode field is deliberately not examined.
module fpu_insn_decode
    import fpu_pkg::*;
#(
    parameter int ENABLE_MULT = 1
) (
    input  logic [31:0] pcpi_insn,
    output logic        match,
    output logic [1:0]  fpu_op
);

    logic unused_insn;
    assign unused_insn = ^pcpi_insn[24:7];

    always_comb begin
        match  = 1'b0;
        fpu_op = FPU_OP_ADD;
        if (pcpi_insn[6:0] == OPCODE_OP_FP) begin
            case (pcpi_insn[31:25])
                FUNCT7_FADD: begin
                    match  = 1'b1;
                    fpu_op = FPU_OP_ADD;
                end
                FUNCT7_FSUB: begin
                    match  = 1'b1;
                    fpu_op = FPU_OP_SUB;
                end
                FUNCT7_FMUL: begin
                    if (ENABLE_MULT != 0) begin
                        match  = 1'b1;
                        fpu_op = FPU_OP_MUL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fpu_pcpi_sequencer.sv
// PCPI controller that runs one operation at a time on a shared FP32 core.
// Define FPU_SEQ_TIMEOUT_EN to build the hung-FPU watchdog and the sticky seq_err flag.
module fpu_pcpi_sequencer
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ENABLE_MULT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        fpu_start,
    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        seq_err
);

    seq_state_t state;
    logic       dec_match;
    logic [1:0] dec_op;
    logic       resp_to_abort;
    logic       timeout_fire;

    fpu_insn_decode #(
        .ENABLE_MULT (ENABLE_MULT)
    ) u_decode (
        .pcpi_insn (pcpi_insn),
        .match     (dec_match),
        .fpu_op    (dec_op)
    );

    // Handshake outputs are pure state decodes, so an async reset clears them at once.
    assign fpu_start  = (state == ST_ISSUE);
    assign pcpi_wait  = (state == ST_ISSUE) || (state == ST_WAIT);
    assign pcpi_ready = (state == ST_RESP);
    assign pcpi_wr    = (state == ST_RESP);

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // A done or an abort in the expiry cycle takes priority over the forced response.
    assign timeout_fire = (state == ST_WAIT) && pcpi_valid && !fpu_done &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq_err <= 1'b0;
        end else if (timeout_fire) begin
            seq_err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_fire   = 1'b0;
    assign seq_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            fpu_op        <= FPU_OP_ADD;
            fpu_a         <= '0;
            fpu_b         <= '0;
            pcpi_rd       <= '0;
            resp_to_abort <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pcpi_valid && dec_match) begin
                        fpu_op <= dec_op;
                        fpu_a  <= pcpi_rs1;
                        fpu_b  <= pcpi_rs2;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= pcpi_valid ? ST_WAIT : ST_ABORT;
                end
                ST_WAIT: begin
                    if (!pcpi_valid) begin
                        state <= fpu_done ? ST_IDLE : ST_ABORT;
                    end else if (fpu_done) begin
                        pcpi_rd       <= fpu_result;
                        resp_to_abort <= 1'b0;
                        state         <= ST_RESP;
                    end else if (timeout_fire) begin
                        pcpi_rd       <= FP32_CANON_NAN;
                        resp_to_abort <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // After a forced response the late done must still be swallowed.
                    state <= resp_to_abort ? ST_ABORT : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!pcpi_valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (fpu_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_pcpi_sequencer.sv
// Scoreboard bench for fpu_pcpi_sequencer with a behavioural FPU responder.
// Build with FPU_SEQ_TIMEOUT_EN defined to also exercise the watchdog path.
module tb_fpu_pcpi_sequencer;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = '0;
    logic [31:0] pcpi_rs1 = '0;
    logic [31:0] pcpi_rs2 = '0;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, fpu_start, fpu_done, seq_err;
    logic [31:0] pcpi_rd, fpu_a, fpu_b, fpu_result;
    logic [1:0]  fpu_op;

    logic        pcpi_valid2 = 1'b0;
    logic        fpu_done2 = 1'b0;
    logic        pcpi_wr2, pcpi_wait2, pcpi_ready2, fpu_start2, seq_err2;
    logic [31:0] pcpi_rd2, fpu_a2, fpu_b2;
    logic [1:0]  fpu_op2;

    always #5 clk = ~clk;

    fpu_pcpi_sequencer #(.TIMEOUT_CYCLES(16), .ENABLE_MULT(1)) dut (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .fpu_start(fpu_start),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done),
        .fpu_result(fpu_result), .seq_err(seq_err)
    );

    fpu_pcpi_sequencer #(.TIMEOUT_CYCLES(16), .ENABLE_MULT(0)) dut_nomul (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid2), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr2), .pcpi_rd(pcpi_rd2),
        .pcpi_wait(pcpi_wait2), .pcpi_ready(pcpi_ready2), .fpu_start(fpu_start2),
        .fpu_op(fpu_op2), .fpu_a(fpu_a2), .fpu_b(fpu_b2), .fpu_done(fpu_done2),
        .fpu_result(32'h0), .seq_err(seq_err2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int ready_cnt = 0;

    logic [65:0] start_q[$];
    logic [31:0] resp_q[$];
    logic [65:0] s_exp;
    logic [31:0] r_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the FPU arithmetic: exact values for the directed vectors,
    // an arbitrary but deterministic mix otherwise.
    function automatic logic [31:0] fake_fpu(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
    endfunction

    // FPU model: samples start, raises done lat+1 cycles after the start cycle;
    // lat=0 models a hung FPU. man_done lets stimulus inject done pulses directly.
    int          fpu_lat = 3;
    int          fcnt = 0;
    logic        done_m = 1'b0;
    logic        man_done = 1'b0;
    logic [31:0] res_m = '0;

    always @(posedge clk) begin
        done_m <= 1'b0;
        if (fpu_start) begin
            fcnt  <= fpu_lat;
            res_m <= fake_fpu(fpu_op, fpu_a, fpu_b);
        end else if (fcnt > 1) begin
            fcnt <= fcnt - 1;
        end else if (fcnt == 1) begin
            fcnt   <= 0;
            done_m <= 1'b1;
        end
    end

    assign fpu_done   = done_m | man_done;
    assign fpu_result = res_m;

    // Monitor: pops expected issue and response entries as the DUT presents them.
    always @(negedge clk) begin
        if (fpu_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (start_q.size() == 0) begin
                check("start_unexpected", 128'(1), 128'(0));
            end else begin
                s_exp = start_q.pop_front();
                check("start_operands", 128'({fpu_op, fpu_a, fpu_b}), 128'(s_exp));
            end
        end
        if (pcpi_ready) begin
            ready_cnt++;
            if (resp_q.size() == 0) begin
                check("ready_unexpected", 128'(pcpi_rd), 128'(0));
            end else begin
                r_exp = resp_q.pop_front();
                check("resp_rd", 128'(pcpi_rd), 128'(r_exp));
                check("resp_wr_wait", 128'({pcpi_wr, pcpi_wait}), 128'(2'b10));
            end
        end
    end

    task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_rd,
                         input int lat, input int exp_lat);
        int acc;
        int got;
        int s0;
        @(posedge clk); #1;
        fpu_lat    = lat;
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        start_q.push_back({op, a, b});
        resp_q.push_back(exp_rd);
        acc = cyc;
        s0  = start_cnt;
        got = -1;
        for (int i = 0; i < 100 && got < 0; i++) begin
            @(negedge clk);
            if (pcpi_ready) got = cyc;
        end
        if (got < 0) begin
            check("ready_timeout", 128'(0), 128'(1));
            resp_q.delete();
        end else begin
            check("ready_latency", 128'(got - acc), 128'(exp_lat));
        end
        check("start_count", 128'(start_cnt - s0), 128'(1));
        check("start_cycle", 128'(start_cyc - acc), 128'(1));
        @(posedge clk); #1;
        pcpi_valid = 1'b0;
    endtask

    task automatic no_resp(input logic [31:0] insn, input string name);
        logic bad;
        bad = 1'b0;
        @(posedge clk); #1;
        pcpi_insn  = insn;
        pcpi_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bad |= pcpi_wait | pcpi_ready | fpu_start;
        end
        check(name, 128'(bad), 128'(0));
        @(posedge clk); #1;
        pcpi_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r0;
        logic bad;
        logic [1:0] op;
        logic [31:0] a, b;
        logic [2:0] rm;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              128'({pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, fpu_start, fpu_op, fpu_a, fpu_b, seq_err}),
              128'(0));
        resetn = 1'b1;

        // Directed fadd / fsub / fmul, FPU latency 3 -> ready 6 cycles after acceptance
        do_op(32'h00310253, 32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 3, 6);
        do_op(32'h08310253, 32'h40400000, 32'h3F800000, 2'd1, 32'h40000000, 3, 6);
        do_op(32'h10310253, 32'h40000000, 32'h40400000, 2'd2, 32'h40C00000, 3, 6);
        do_op(32'h00317253, 32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 1, 4);

        // fmul on the multiplier-less instance is unsupported
        bad = 1'b0;
        @(posedge clk); #1;
        pcpi_insn   = 32'h10310253;
        pcpi_valid2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bad |= pcpi_wait2 | pcpi_ready2 | fpu_start2;
        end
        check("nomul_fmul_ignored", 128'(bad), 128'(0));
        @(posedge clk); #1;
        pcpi_valid2 = 1'b0;

        // Unsupported encodings
        no_resp(32'h18310253, "fdiv_ignored");
        no_resp(32'h00310233, "non_opfp_ignored");

        // Abort: valid drops one cycle after start, done arrives 5 cycles later;
        // a new fadd presented during ABORT waits for the swallowed done.
        @(posedge clk); #1;
        n          = cyc;
        r0         = ready_cnt;
        fpu_lat    = 0;
        pcpi_insn  = 32'h00310253;
        pcpi_rs1   = 32'h12345678;
        pcpi_rs2   = 32'h0BADF00D;
        pcpi_valid = 1'b1;
        start_q.push_back({2'd0, 32'h12345678, 32'h0BADF00D});
        @(posedge clk); #1;
        @(posedge clk); #1;
        pcpi_valid = 1'b0;
        bad = 1'b0;
        for (int i = 3; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                fpu_lat    = 3;
                pcpi_rs1   = 32'h3F800000;
                pcpi_rs2   = 32'h40000000;
                pcpi_valid = 1'b1;
                start_q.push_back({2'd0, 32'h3F800000, 32'h40000000});
                resp_q.push_back(32'h40400000);
            end
            man_done = (i == 7);
            @(negedge clk);
            bad |= pcpi_wait | pcpi_ready | fpu_start;
        end
        check("abort_quiet", 128'(bad), 128'(0));
        check("abort_no_ready", 128'(ready_cnt - r0), 128'(0));
        begin
            int got;
            got = -1;
            for (int i = 0; i < 50 && got < 0; i++) begin
                @(negedge clk);
                if (pcpi_ready) got = cyc;
            end
            check("abort_new_start_cycle", 128'(start_cyc - n), 128'(9));
            check("abort_new_ready_cycle", 128'(got - n), 128'(14));
        end
        @(posedge clk); #1;
        pcpi_valid = 1'b0;

        // Back-to-back random operations
        for (int k = 0; k < 100; k++) begin
            op = 2'($urandom_range(0, 2));
            a  = $urandom;
            b  = $urandom;
            rm = 3'($urandom_range(0, 7));
            n  = $urandom_range(1, 4);
            do_op({3'b000, op, 2'b00, 5'd3, 5'd2, rm, 5'd4, 7'h53}, a, b, op,
                  fake_fpu(op, a, b), n, 3 + n);
        end
        check("seq_err_clear", 128'(seq_err), 128'(0));

        // Asynchronous reset while waiting on the FPU, then a stray done
        @(posedge clk); #1;
        fpu_lat    = 10;
        pcpi_insn  = 32'h00310253;
        pcpi_rs1   = 32'hCAFEF00D;
        pcpi_rs2   = 32'h00C0FFEE;
        pcpi_valid = 1'b1;
        start_q.push_back({2'd0, 32'hCAFEF00D, 32'h00C0FFEE});
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("reset_async_outputs",
              128'({pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, fpu_start, fpu_op, fpu_a, fpu_b, seq_err}),
              128'(0));
        pcpi_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        r0  = ready_cnt;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad |= pcpi_wait | pcpi_ready | fpu_start;
        end
        check("stray_done_ignored", 128'(bad), 128'(0));
        check("stray_done_no_ready", 128'(ready_cnt - r0), 128'(0));
        do_op(32'h00310253, 32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 3, 6);

`ifdef FPU_SEQ_TIMEOUT_EN
        // Hung FPU: forced NaN after 16 WAIT cycles, sticky seq_err, late done swallowed
        do_op(32'h00310253, 32'h3F800000, 32'h40000000, 2'd0, FP32_CANON_NAN, 0, 18);
        check("timeout_seq_err", 128'(seq_err), 128'(1));
        @(posedge clk); #1;
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        do_op(32'h08310253, 32'h40400000, 32'h3F800000, 2'd1, 32'h40000000, 2, 5);
        check("seq_err_sticky", 128'(seq_err), 128'(1));
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("seq_err_reset", 128'(seq_err), 128'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 128'(resp_q.size() + start_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
